// File: rtl/b_tile_pingpong_buffer.sv
// b_tile_pingpong_buffer: two-bank B-tile store; the loader fills one bank while the array reads the other.
module b_tile_pingpong_buffer #(
  parameter int LANES  = 32,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DATA_W-1:0]  in_data,
  output logic                     rd_tile_valid,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [LANES*DATA_W-1:0]  rd_data,
  input  logic                     rd_release,
  output logic [1:0]               tiles_ready,
  output logic                     err_release
);
  localparam int W  = LANES*DATA_W;
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [2][DEPTH];
  logic          r_wr_bank, r_rd_bank, r_err;
  logic [AW-1:0] r_wr_ptr;
  logic [1:0]    r_full, w_full_nx;
  logic [W-1:0]  r_rd_data;
  logic          w_wr, w_wr_last, w_rel, w_rd, w_addr_ok;
  assign in_ready      = !r_full[r_wr_bank];
  assign rd_tile_valid = r_full[r_rd_bank];
  assign tiles_ready   = {1'b0, r_full[0]} + {1'b0, r_full[1]};
  assign err_release   = r_err;
  assign rd_data       = r_rd_data;
  assign w_wr          = in_valid && in_ready && !flush;
  assign w_wr_last     = w_wr && (r_wr_ptr == AW'(DEPTH-1));
  assign w_rel         = rd_release && rd_tile_valid;
  assign w_rd          = rd_en && rd_tile_valid && !flush;
  assign w_addr_ok     = 32'(rd_addr) < DEPTH;
  // writer and reader never own the same bank, so both updates can land together
  always_comb begin
    w_full_nx = r_full;
    if (w_wr_last) w_full_nx[r_wr_bank] = 1'b1;
    if (w_rel) w_full_nx[r_rd_bank] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_ptr  <= '0;
      r_full    <= '0;
      r_err     <= 1'b0;
    end else if (flush) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_ptr  <= '0;
      r_full    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_full <= w_full_nx;
      if (w_wr) r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + 1'b1;
      if (w_wr_last) r_wr_bank <= !r_wr_bank;
      if (w_rel) r_rd_bank <= !r_rd_bank;
      if (rd_release && !rd_tile_valid) r_err <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_bank][r_wr_ptr] <= in_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else if (w_rd) r_rd_data <= w_addr_ok ? r_mem[r_rd_bank][rd_addr[AW-1:0]] : '0;
  end
endmodule

// File: tb/tb_b_tile_pingpong_buffer.sv
// tb_b_tile_pingpong_buffer: directed ping-pong fill/read/release sequence with immediate-assertion checks.
module tb_b_tile_pingpong_buffer;
  localparam int LANES = 32, DATA_W = 8, DEPTH = 16, ADDR_W = 5;
  localparam int W = LANES*DATA_W;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, rd_en = 0, rd_release = 0;
  logic [W-1:0] in_data = '0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic in_ready, rd_tile_valid, err_release;
  logic [W-1:0] rd_data;
  logic [1:0] tiles_ready;
  int n_chk = 0, n_err = 0;
  b_tile_pingpong_buffer #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rd_tile_valid(rd_tile_valid), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_release(rd_release), .tiles_ready(tiles_ready), .err_release(err_release)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] row(input int r);
    logic [7:0] b;
    b = r[7:0];
    return {LANES{b}};
  endfunction
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic write_rows(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      chk("wr_in_ready", in_ready, 1);
      in_valid = 1;
      in_data = row(first + i);
      step();
    end
    in_valid = 0;
  endtask
  task automatic rd(input int a);
    rd_en = 1;
    rd_addr = a[ADDR_W-1:0];
    step();
    rd_en = 0;
  endtask
  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tile_valid", rd_tile_valid, 0);
    chk("rst_tiles", tiles_ready, 0);
    chk("rst_err", err_release, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1;
    step();
    // first tile: rows 0..15 into bank 0
    write_rows(0, 15);
    chk("pre_last_tiles", tiles_ready, 0);
    write_rows(15, 1);
    chk("t1_tiles", tiles_ready, 1);
    chk("t1_valid", rd_tile_valid, 1);
    chk("t1_in_ready", in_ready, 1);
    rd(5);
    chk("t1_rd5", rd_data, row(5));
    // second tile fills bank 1; writer stalls
    write_rows(16, 16);
    chk("t2_in_ready", in_ready, 0);
    chk("t2_tiles", tiles_ready, 2);
    in_valid = 1;
    in_data = row(32);
    step();
    step();
    chk("stall_in_ready", in_ready, 0);
    chk("stall_tiles", tiles_ready, 2);
    rd(0);
    chk("stall_bank0_intact", rd_data, row(0));
    rd_release = 1;
    step();
    rd_release = 0;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_tiles", tiles_ready, 1);
    chk("rel_valid", rd_tile_valid, 1);
    step();
    in_valid = 0;
    // read and release bank 1 in the same cycle
    rd_en = 1;
    rd_addr = 0;
    rd_release = 1;
    step();
    rd_en = 0;
    rd_release = 0;
    chk("rdrel_data", rd_data, row(16));
    chk("rdrel_valid", rd_tile_valid, 0);
    chk("rdrel_tiles", tiles_ready, 0);
    rd(3);
    chk("rd_no_tile_hold", rd_data, row(16));
    write_rows(33, 15);
    chk("t3_valid", rd_tile_valid, 1);
    rd(0);
    chk("t3_row32_addr0", rd_data, row(32));
    rd(1);
    chk("t3_addr1", rd_data, row(33));
    rd_release = 1;
    step();
    rd_release = 0;
    chk("t3_rel_tiles", tiles_ready, 0);
    // release with nothing full
    rd_release = 1;
    step();
    rd_release = 0;
    chk("err_set", err_release, 1);
    chk("err_tiles", tiles_ready, 0);
    write_rows(48, 16);
    chk("err_no_toggle_valid", rd_tile_valid, 1);
    chk("err_sticky", err_release, 1);
    // flush overrides a same-cycle read, release and write
    flush = 1;
    rd_en = 1;
    rd_addr = 0;
    rd_release = 1;
    in_valid = 1;
    in_data = row(99);
    step();
    flush = 0;
    rd_en = 0;
    rd_release = 0;
    in_valid = 0;
    chk("flush_err", err_release, 0);
    chk("flush_tiles", tiles_ready, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_rd_hold", rd_data, row(33));
    // partial tile then async reset mid-beat
    write_rows(100, 7);
    in_valid = 1;
    in_data = row(107);
    #2;
    rst_n = 0;
    in_valid = 0;
    #1;
    chk("arst_tiles", tiles_ready, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_in_ready", in_ready, 1);
    #3;
    rst_n = 1;
    step();
    write_rows(200, 16);
    chk("post_rst_tiles", tiles_ready, 1);
    rd(0);
    chk("post_rst_addr0", rd_data, row(200));
    rd(15);
    chk("post_rst_addr15", rd_data, row(215));
    // final write to bank 0 coincides with release of bank 1
    rd_release = 1;
    step();
    rd_release = 0;
    write_rows(300, 16);
    chk("b1_full_tiles", tiles_ready, 1);
    write_rows(400, 15);
    in_valid = 1;
    in_data = row(415);
    rd_release = 1;
    step();
    in_valid = 0;
    rd_release = 0;
    chk("coinc_tiles", tiles_ready, 1);
    chk("coinc_valid", rd_tile_valid, 1);
    chk("coinc_in_ready", in_ready, 1);
    rd(0);
    chk("coinc_addr0", rd_data, row(400));
    rd(15);
    chk("coinc_addr15", rd_data, row(415));
    rd(16);
    chk("oob_zero", rd_data, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
